// File: rtl/lease_sampler_pkg.sv
// Shared types and defaults for the lease sampler and its host-side reader.
package lease_sampler_pkg;

  localparam int BW_BUF_ADDR_DEF = 13;
  localparam int N_BUFFER_DEF    = 8191;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, LOAD, SEND, CLEAR, DONE
  } rd_state_e;

  // Order in which a record's fields leave on the stream
  localparam logic [2:0] WORD_ADDR     = 3'd0;
  localparam logic [2:0] WORD_INTERVAL = 3'd1;
  localparam logic [2:0] WORD_TRACE_LO = 3'd2;
  localparam logic [2:0] WORD_TRACE_HI = 3'd3;
  localparam logic [2:0] WORD_TARGET   = 3'd4;

  typedef struct packed {
    logic [31:0] interval;
    logic [31:0] address;
    logic [63:0] trace;
    logic [31:0] target;
  } record_t;

endpackage

// File: rtl/record_serializer.sv
// Holds one 160-bit record and streams it as five 32-bit words.
// Fields pass through untouched (negative intervals are markers, not data to fix).
module record_serializer
  import lease_sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  record_t     rec,
  input  logic        stop,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic [2:0]  word,
  output logic        xfer,
  output logic        done
);

  record_t hold;

  assign xfer = valid & ready;
  assign done = xfer & (word == WORD_TARGET);

  // Capture on load; advance only on a handshake so data holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      valid <= 1'b0;
      word  <= WORD_ADDR;
    end else if (load) begin
      hold  <= rec;
      valid <= 1'b1;
      word  <= WORD_ADDR;
    end else if (xfer) begin
      if (word == WORD_TARGET || stop) valid <= 1'b0;
      else                             word  <= word + 3'd1;
    end
  end

  // Word select
  always_comb begin
    data = '0;
    case (word)
      WORD_ADDR:     data = hold.address;
      WORD_INTERVAL: data = hold.interval;
      WORD_TRACE_LO: data = hold.trace[31:0];
      WORD_TRACE_HI: data = hold.trace[63:32];
      WORD_TARGET:   data = hold.target;
      default:       data = '0;
    endcase
  end

endmodule

// File: rtl/lease_sampler_reader.sv
// Drain engine: walks the record buffer, streams each record, then clears the buffer.
module lease_sampler_reader
  import lease_sampler_pkg::*;
#(
  parameter int BW_BUF_ADDR = BW_BUF_ADDR_DEF,
  parameter int N_BUFFER    = N_BUFFER_DEF,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   start_i,
  input  logic                   full_i,
  input  logic [31:0]            used_i,
  input  logic                   abort_i,
  output logic [BW_BUF_ADDR-1:0] buf_addr_o,
  output logic                   buf_rd_o,
  input  logic [31:0]            interval_i,
  input  logic [31:0]            address_i,
  input  logic [63:0]            trace_i,
  input  logic [31:0]            target_i,
  output logic [31:0]            data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   clear_o,
  output logic                   busy_o,
  output logic [31:0]            records_o
);

  // One extra index bit so a full buffer (N_BUFFER+1 records) ends without wrapping
  localparam int BW_IDX = BW_BUF_ADDR + 1;
  localparam logic [BW_IDX-1:0] MAX_COUNT = BW_IDX'(N_BUFFER + 1);

  rd_state_e         state;
  logic [BW_IDX-1:0] count, index, count_next;
  logic [1:0]        wcnt;
  logic              full_q, armed, abort_pend;
  logic              start_cond, stop, ser_load, last_rec;
  logic [2:0]        word;
  logic              xfer, done;
  record_t           rec;

  // armed blocks re-draining a buffer whose full flag has not yet dropped
  assign start_cond = armed & (start_i | (full_i & ~full_q));
  assign count_next = (used_i > 32'(N_BUFFER + 1)) ? MAX_COUNT : used_i[BW_IDX-1:0];
  assign stop       = abort_i | abort_pend;
  assign ser_load   = (state == LOAD) & ~abort_i;
  assign last_rec   = (index == count - BW_IDX'(1));
  assign rec        = '{interval: interval_i, address: address_i, trace: trace_i, target: target_i};

  // Outputs decode straight from the state register
  assign busy_o     = (state != IDLE) && (state != DONE);
  assign buf_rd_o   = (state == ISSUE) || (state == WAIT) || (state == LOAD) || (state == SEND);
  assign clear_o    = (state == CLEAR);
  assign buf_addr_o = buf_rd_o ? index[BW_BUF_ADDR-1:0] : '0;
  assign last_o     = valid_o & (state == SEND) & (word == WORD_TARGET) & last_rec;

  record_serializer u_ser (
    .clk   (clock_i),
    .rst_n (resetn_i),
    .load  (ser_load),
    .rec   (rec),
    .stop  (stop),
    .ready (ready_i),
    .valid (valid_o),
    .data  (data_o),
    .word  (word),
    .xfer  (xfer),
    .done  (done)
  );

  // Drain sequencing, record index and the transmitted-record count
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      wcnt       <= '0;
      full_q     <= 1'b0;
      armed      <= 1'b1;
      abort_pend <= 1'b0;
      records_o  <= '0;
    end else begin
      full_q <= full_i;
      if (!full_i) armed <= 1'b1;
      case (state)
        IDLE: if (start_cond) begin
          count     <= count_next;
          index     <= '0;
          records_o <= '0;
          armed     <= 1'b0;
          state     <= (count_next == '0) ? CLEAR : ISSUE;
        end
        ISSUE: begin
          wcnt <= '0;
          if (abort_i)             state <= CLEAR;
          else if (RD_LATENCY > 1) state <= WAIT;
          else                     state <= LOAD;
        end
        WAIT: begin
          if (abort_i)                          state <= CLEAR;
          else if (wcnt == 2'(RD_LATENCY - 2)) state <= LOAD;
          else                                  wcnt  <= wcnt + 2'd1;
        end
        LOAD: begin
          abort_pend <= 1'b0;
          state      <= abort_i ? CLEAR : SEND;
        end
        SEND: begin
          if (abort_i) abort_pend <= 1'b1;
          if (done) begin
            records_o  <= records_o + 32'd1;
            index      <= index + BW_IDX'(1);
            abort_pend <= 1'b0;
            state      <= (last_rec || stop) ? CLEAR : ISSUE;
          end else if (xfer && stop) begin
            abort_pend <= 1'b0;
            state      <= CLEAR;
          end
        end
        CLEAR:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lease_sampler_reader.sv
// Scoreboard bench for the lease sampler drain engine.
module tb_lease_sampler_reader;

  logic        clk = 1'b0;
  logic        resetn, start, full, abort;
  logic [31:0] used;
  logic [12:0] buf_addr;
  logic        buf_rd, valid, ready, last, clear, busy;
  logic [31:0] data, records;
  logic [31:0] m_int, m_addr, m_tgt;
  logic [63:0] m_tr;
  logic [31:0] hi_tag;
  logic        bp_mode, rdy_fix, tog;

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t sb_q[$];
  exp_t e;

  int n_vec = 0, n_err = 0;
  int clear_cnt = 0, last_cnt = 0, xfer_cnt = 0, valid_cnt = 0, drains = 0, busy_cyc = 0;
  int max_addr = 0;
  logic busy_q = 1'b0, stall_q = 1'b0;
  logic [31:0] stall_d = '0;

  always #5 clk = ~clk;

  assign ready = bp_mode ? tog : rdy_fix;

  lease_sampler_reader #(.BW_BUF_ADDR(13), .N_BUFFER(8191), .RD_LATENCY(1)) dut (
    .clock_i(clk), .resetn_i(resetn), .start_i(start), .full_i(full), .used_i(used),
    .abort_i(abort), .buf_addr_o(buf_addr), .buf_rd_o(buf_rd),
    .interval_i(m_int), .address_i(m_addr), .trace_i(m_tr), .target_i(m_tgt),
    .data_o(data), .valid_o(valid), .ready_i(ready), .last_o(last),
    .clear_o(clear), .busy_o(busy), .records_o(records)
  );

  // BRAM model, one cycle read latency
  always @(posedge clk) begin
    m_addr <= 32'h100 + 32'(buf_addr);
    m_int  <= 32'(buf_addr) + 32'd5;
    m_tr   <= {hi_tag | 32'(buf_addr), 32'(buf_addr)};
    m_tgt  <= 32'hA0 + 32'(buf_addr);
  end

  initial begin
    tog = 1'b0;
    forever begin @(posedge clk); #1 tog = ~tog; end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_rec(int n, bit is_last);
    sb_q.push_back('{32'h100 + 32'(n), 1'b0});
    sb_q.push_back('{32'(n) + 32'd5, 1'b0});
    sb_q.push_back('{32'(n), 1'b0});
    sb_q.push_back('{hi_tag | 32'(n), 1'b0});
    sb_q.push_back('{32'hA0 + 32'(n), is_last});
  endtask

  // Monitor: pops expected words on each handshake and tracks side effects
  always @(negedge clk) if (resetn) begin
    if (clear) clear_cnt++;
    if (last) last_cnt++;
    if (valid) valid_cnt++;
    if (busy) busy_cyc++;
    if (busy && !busy_q) drains++;
    busy_q = busy;
    if (buf_rd && int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
    if (stall_q) begin
      chk("hold_valid", 64'(valid), 64'd1);
      if (valid) chk("hold_data", 64'(data), 64'(stall_d));
    end
    stall_q = valid & ~ready;
    stall_d = data;
    if (valid && ready) begin
      xfer_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_word: got %0h expected no transfer", data);
      end else begin
        e = sb_q.pop_front();
        chk("word", 64'(data), 64'(e.d));
        chk("last", 64'(last), 64'(e.l));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin @(negedge clk); c++; end
    chk("drain_ends_in_budget", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, l0, x0, v0, d0, b0, c;
    resetn = 1'b0; start = 1'b0; full = 1'b0; abort = 1'b0; used = '0;
    hi_tag = '0; bp_mode = 1'b0; rdy_fix = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", 64'(valid), 0); chk("rst_busy", 64'(busy), 0);
    chk("rst_rd", 64'(buf_rd), 0);   chk("rst_clear", 64'(clear), 0);
    chk("rst_records", 64'(records), 0); chk("rst_addr", 64'(buf_addr), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic drain of 3, used_i changed after start and a start while busy
    c0 = clear_cnt; l0 = last_cnt; d0 = drains; b0 = busy_cyc;
    for (int n = 0; n < 3; n++) push_rec(n, n == 2);
    used = 32'd3;
    pulse_start();
    used = 32'd9;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
    wait_idle(200);
    chk("basic_records", 64'(records), 64'd3);
    chk("basic_clear", 64'(clear_cnt - c0), 64'd1);
    chk("basic_last", 64'(last_cnt - l0), 64'd1);
    chk("basic_drains", 64'(drains - d0), 64'd1);
    chk("basic_busy_cycles", 64'(busy_cyc - b0), 64'd22);
    chk("basic_sb_empty", 64'(sb_q.size()), 64'd0);

    // Backpressure, 2 records, ready toggling every cycle
    hi_tag = 32'hC0DE0000; x0 = xfer_cnt;
    for (int n = 0; n < 2; n++) push_rec(n, n == 1);
    used = 32'd2; bp_mode = 1'b1;
    pulse_start();
    wait_idle(200);
    bp_mode = 1'b0;
    chk("bp_xfers", 64'(xfer_cnt - x0), 64'd10);
    chk("bp_records", 64'(records), 64'd2);
    chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Empty buffer: clear one cycle after start, no stream activity
    v0 = valid_cnt; c0 = clear_cnt;
    used = 32'd0;
    pulse_start();
    @(negedge clk); chk("empty_clear_hi", 64'(clear), 64'd1);
    @(negedge clk); chk("empty_clear_lo", 64'(clear), 64'd0);
    wait_idle(50);
    chk("empty_no_valid", 64'(valid_cnt - v0), 64'd0);
    chk("empty_clear_cnt", 64'(clear_cnt - c0), 64'd1);
    chk("empty_records", 64'(records), 64'd0);

    // full_i held high: one drain only until it falls and rises again
    hi_tag = '0; d0 = drains;
    for (int n = 0; n < 2; n++) push_rec(n, n == 1);
    used = 32'd2;
    @(posedge clk); #1 full = 1'b1;
    repeat (2) @(posedge clk);
    wait_idle(200);
    repeat (20) @(posedge clk);
    chk("full_one_drain", 64'(drains - d0), 64'd1);
    #1 full = 1'b0;
    repeat (3) @(posedge clk);
    for (int n = 0; n < 2; n++) push_rec(n, n == 1);
    #1 full = 1'b1;
    repeat (2) @(posedge clk);
    wait_idle(200);
    chk("full_two_drains", 64'(drains - d0), 64'd2);
    chk("full_sb_empty", 64'(sb_q.size()), 64'd0);
    full = 1'b0;

    // Abort during word 2 of the second record of 4, with ready held off
    c0 = clear_cnt; l0 = last_cnt; x0 = xfer_cnt;
    push_rec(0, 1'b0);
    sb_q.push_back('{32'h101, 1'b0});
    sb_q.push_back('{32'd6, 1'b0});
    sb_q.push_back('{32'd1, 1'b0});
    used = 32'd4;
    pulse_start();
    c = 0;
    while (xfer_cnt - x0 < 7 && c < 200) begin @(posedge clk); c++; end
    #1 rdy_fix = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rdy_fix = 1'b1;
    wait_idle(200);
    chk("abort_records", 64'(records), 64'd1);
    chk("abort_xfers", 64'(xfer_cnt - x0), 64'd8);
    chk("abort_no_last", 64'(last_cnt - l0), 64'd0);
    chk("abort_clear", 64'(clear_cnt - c0), 64'd1);
    chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset while streaming
    for (int n = 0; n < 3; n++) push_rec(n, n == 2);
    used = 32'd3;
    pulse_start();
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!valid && c < 50);
    chk("rstmid_streaming", 64'(valid), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_valid", 64'(valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_rd", 64'(buf_rd), 64'd0);
    chk("rstmid_clear", 64'(clear), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("rstmid_records", 64'(records), 64'd0);
    sb_q.delete();
    c0 = clear_cnt;
    resetn = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("rstmid_no_clear", 64'(clear_cnt - c0), 64'd0);
    chk("rstmid_idle", 64'(busy), 64'd0);

    // Clamp: used above capacity drains exactly N_BUFFER+1 records
    c0 = clear_cnt; l0 = last_cnt;
    for (int n = 0; n < 8192; n++) push_rec(n, n == 8191);
    used = 32'd20000;
    pulse_start();
    wait_idle(60000);
    chk("clamp_records", 64'(records), 64'd8192);
    chk("clamp_max_addr", 64'(max_addr), 64'd8191);
    chk("clamp_clear", 64'(clear_cnt - c0), 64'd1);
    chk("clamp_last", 64'(last_cnt - l0), 64'd1);
    chk("clamp_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lease_sampler_reader.md
Name: lease_sampler_reader

Overview:
- Host-side drain engine for the lease sampler record buffer. The sampler writes records; this block reads them out.
- When the sampler reports its buffer full, or software requests a drain, the block walks buffer addresses 0..used-1 and reads each record from the four buffer BRAMs: interval, address, trace, target.
- Each record is serialised as five 32-bit words onto a valid/ready stream toward the host comm path.
- After the last word it pulses the buffer clear so sampling can resume.

Parameters:
- BW_BUF_ADDR, 13, width of buffer address bus.
- N_BUFFER, 8191, highest legal buffer index; a used count above N_BUFFER+1 is clamped to N_BUFFER+1.
- RD_LATENCY, 1, BRAM read latency in cycles from address to q. Legal range 1..2.

Ports:
- clock_i  in  1  single clock, rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- start_i  in  1  software drain request (single-cycle pulse).
- full_i  in  1  sampler buffer-full flag; a rising edge starts a drain.
- used_i  in  32  number of valid records, sampled at drain start.
- abort_i  in  1  terminates the drain after the current word.
- buf_addr_o  out  BW_BUF_ADDR  buffer read address.
- buf_rd_o  out  1  high while the reader owns the buffer address mux.
- interval_i  in  32  BRAM q, interval.
- address_i  in  32  BRAM q, pc/phase.
- trace_i  in  64  BRAM q, trace count.
- target_i  in  32  BRAM q, tag.
- data_o  out  32  stream word.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  marks word 4 of the final record.
- clear_o  out  1  one-cycle buffer clear pulse to the sampler.
- busy_o  out  1  drain in progress.
- records_o  out  32  records fully transmitted in the current or last drain.

Behaviour:
- Reset values: all outputs 0; state IDLE; records_o 0.
- IDLE:
  - A start condition is start_i=1, or full_i high now and low in the previous cycle.
  - On a start condition, latch count = min(used_i, N_BUFFER+1), clear records_o, set busy_o=1.
  - If count=0, go to CLEAR; otherwise go to ISSUE with index=0.
- ISSUE:
  - buf_rd_o=1, buf_addr_o=index.
  - Wait RD_LATENCY cycles (WAIT state), then LOAD.
- LOAD:
  - Capture interval_i, address_i, trace_i and target_i into a 160-bit holding register.
  - Set word=0 and go to SEND.
- SEND:
  - valid_o=1. data_o by word: 0=address, 1=interval, 2=trace[31:0], 3=trace[63:32], 4=target.
  - A word transfers when valid_o & ready_i. data_o stays stable while ready_i=0.
  - valid_o stays high between words of one record and is not dropped without a transfer.
  - last_o=1 only on word 4 when index=count-1.
  - When word 4 transfers: records_o+=1, index+=1. If index reaches count, go to CLEAR; otherwise go to ISSUE.
- CLEAR:
  - clear_o=1 for exactly one cycle, buf_rd_o=0, then DONE.
- DONE:
  - busy_o=0, return to IDLE.
  - A new start is not accepted until full_i has been observed low (prevents re-draining a still-full buffer before the clear takes effect).
- Interval sign: words pass through unmodified. Negative (2's-complement) intervals are the sampler's eviction and writeout markers and are not interpreted.
- Throughput: one record per 5+RD_LATENCY+1 cycles with ready_i held high.
- buf_rd_o is held from ISSUE through SEND so the host does not fight the address mux.
- Start during busy: ignored, no re-latch of count.
- abort_i in SEND: finish the current word's handshake, then go to CLEAR. last_o is not asserted.
- abort_i in ISSUE, WAIT or LOAD: go to CLEAR directly.
- Abort and the final transfer in the same cycle: the final transfer completes and last_o is asserted; one clear pulse only.
- Reset mid-drain: immediate return to IDLE with all outputs 0. No clear pulse; the buffer keeps its contents.
- Index width is BW_BUF_ADDR+1 so count=N_BUFFER+1 terminates without wrap.

Decomposition:
- Shared package `lease_sampler_pkg`:
  - Reader state enum (IDLE, ISSUE, WAIT, LOAD, SEND, CLEAR, DONE).
  - Word-select constants WORD_ADDR..WORD_TARGET.
  - BW_BUF_ADDR and N_BUFFER defaults, shared with the sampler.
- One sub-module, `record_serializer`: 160-bit holding register plus 3-bit word counter and valid/ready handshake. It exposes load and done.
- FSM and address counter stay in the top.

Test Plan:
- Basic drain:
  - Stimulus: used_i=3, start_i pulse, ready_i=1, BRAM model returns address=0x100+n, interval=n+5, trace=n, target=0xA0+n.
  - Response: 15 words in order 0x100,5,0,0,0xA0,...; last_o on word 15; one clear_o pulse; records_o=3.
- Backpressure:
  - Stimulus: ready_i toggled 1010... during a 2-record drain.
  - Response: data_o stable while ready=0; exactly 10 transfers, no duplicates.
- Empty and clamp:
  - used_i=0 -> clear_o pulse 1 cycle after start, valid_o never high.
  - used_i=20000 -> count=8192, buf_addr_o reaches 8191 and stops.
- full_i edge:
  - Stimulus: full_i held high across a complete drain.
  - Response: exactly one drain; a second drain only after full_i falls and rises again.
- Abort:
  - Stimulus: abort_i during word 2 of record 1 of 4.
  - Response: word 2 completes, then clear_o, records_o=1, last_o never asserted.
- Reset mid-SEND:
  - Stimulus: resetn_i low asynchronously.
  - Response: valid_o, busy_o, buf_rd_o drop without a clock edge; clear_o stays 0.
